// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle execute unit: ALU opcodes, write
// conditions and the sequencing FSM states.
package mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NAND = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_MUL  = 4'd9
  } op_e;

  localparam logic [1:0] CZ_ALWAYS = 2'b00;
  localparam logic [1:0] CZ_ZERO   = 2'b01;
  localparam logic [1:0] CZ_CARRY  = 2'b10;
  localparam logic [1:0] CZ_ADDC   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Codes above MUL are unassigned and reported as illegal.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'd9);
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file: two operand read ports, one write port and a
// debug read port. R0 has no storage and always reads as zero.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [RA_W-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [RA_W-1:0]  raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [RA_W-1:0]  raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o,
  input  logic [RA_W-1:0]  dbg_addr_i,
  output logic [WIDTH-1:0] dbg_data_o
);

  logic [WIDTH-1:0] regs_q [NREGS-1:1];

  // Register storage with asynchronous clear; writes to R0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : regs_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/mc_exec_unit.sv
// Multicycle execute path: issue capture, operand latch, ALU / iterative
// multiplier, and condition-gated writeback of register and flags.
//
//   state | meaning
//   IDLE  | waiting for start; issue fields captured on start
//   READ  | operands A and B latched from the register file / immediate
//   EXEC  | ALU result (1 cycle) or shift-add multiply (WIDTH cycles)
//   WB    | done pulse; register and flags written if the condition holds
module mc_exec_unit
  import mc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 6,
  parameter int RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [RA_W-1:0]  rs1,
  input  logic [RA_W-1:0]  rs2,
  input  logic [RA_W-1:0]  rd,
  input  logic [IMM_W-1:0] imm,
  input  logic             use_imm,
  input  logic [1:0]       cz,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             skipped,
  output logic             illegal,
  output logic             carry_flag,
  output logic             zero_flag,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int SH_W  = $clog2(WIDTH);

  state_e state_q, state_d;

  logic [3:0]       op_q;
  logic [RA_W-1:0]  rs1_q, rs2_q, rd_q;
  logic [IMM_W-1:0] imm_q;
  logic             use_imm_q;
  logic [1:0]       cz_q;

  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic               cout_q, illegal_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, zero_q;

  logic [WIDTH-1:0]   rdata_a, rdata_b, imm_ext, b_src;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cout;
  logic               exec_last, cond_true, commit, reg_we;
  logic               add_cin;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH:0]     add_ext, sub_ext, sll_ext, srl_ext, mul_sum;
  logic [2*WIDTH-1:0] prod_step;

  mc_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .RA_W  (RA_W)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we_i       (reg_we),
    .waddr_i    (rd_q),
    .wdata_i    (result_q),
    .raddr_a_i  (rs1_q),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (rs2_q),
    .rdata_b_o  (rdata_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign imm_ext = {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign b_src   = use_imm_q ? imm_ext : rdata_b;

  // A multiply finishes on the cycle its countdown reaches zero.
  assign exec_last = (state_q == ST_EXEC) && ((op_q != OP_MUL) || (cnt_q == '0));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_READ;
      ST_READ: begin
        busy    = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (exec_last) state_d = ST_WB;
      end
      ST_WB: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue fields are frozen at acceptance so decode may move on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      cz_q      <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      op_q      <= op;
      rs1_q     <= rs1;
      rs2_q     <= rs2;
      rd_q      <= rd;
      imm_q     <= imm;
      use_imm_q <= use_imm;
      cz_q      <= cz;
    end
  end

  assign add_cin = (cz_q == CZ_ADDC) ? carry_q : 1'b0;
  assign shamt   = b_q[SH_W-1:0];
  assign add_ext = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, add_cin};
  assign sub_ext = {1'b0, a_q} - {1'b0, b_q};
  // The extra bit catches the last bit shifted out; it stays 0 for shamt 0.
  assign sll_ext = {1'b0, a_q} << shamt;
  assign srl_ext = {a_q, 1'b0} >> shamt;

  // One shift-add step: B sits in the low half and is consumed LSB first.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};

  // ALU result and carry; ops that do not define carry pass the flag through.
  always_comb begin
    alu_res  = '0;
    alu_cout = carry_q;
    case (op_q)
      OP_ADD:  {alu_cout, alu_res} = add_ext;
      OP_SUB:  {alu_cout, alu_res} = sub_ext;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_NAND: alu_res = ~(a_q & b_q);
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL:  {alu_cout, alu_res} = sll_ext;
      OP_SRL: begin
        alu_res  = srl_ext[WIDTH:1];
        alu_cout = srl_ext[0];
      end
      OP_MUL: begin
        alu_res  = prod_step[WIDTH-1:0];
        alu_cout = |prod_step[2*WIDTH-1:WIDTH];
      end
      default: begin
        alu_res  = '0;
        alu_cout = carry_q;
      end
    endcase
  end

  // Operand latches, multiplier iteration and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == ST_READ) begin
        a_q    <= rdata_a;
        b_q    <= b_src;
        prod_q <= {{WIDTH{1'b0}}, b_src};
        cnt_q  <= CNT_W'(WIDTH-1);
      end
      if ((state_q == ST_EXEC) && (op_q == OP_MUL)) begin
        prod_q <= prod_step;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (exec_last) begin
        result_q  <= alu_res;
        cout_q    <= alu_cout;
        illegal_q <= !op_is_legal(op_q);
      end
    end
  end

  // Flags cannot move between issue and WB, so the live flags are the
  // issue-time flags for the condition check.
  always_comb begin
    cond_true = 1'b1;
    case (cz_q)
      CZ_CARRY: cond_true = carry_q;
      CZ_ZERO:  cond_true = zero_q;
      default:  cond_true = 1'b1;
    endcase
  end

  assign commit  = (state_q == ST_WB) && !illegal_q && cond_true;
  assign reg_we  = commit && (rd_q != '0);
  assign skipped = (state_q == ST_WB) && !illegal_q && !cond_true;
  assign illegal = (state_q == ST_WB) && illegal_q;
  assign result  = result_q;

  // Architectural flags change only on a committed writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (commit) begin
      carry_q <= cout_q;
      zero_q  <= (result_q == '0);
    end
  end

  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;

endmodule

// File: tb/tb_mc_exec_unit.sv
// Directed bench for mc_exec_unit at WIDTH=16, NREGS=8, IMM_W=6.
module tb_mc_exec_unit;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, use_imm;
  logic [3:0]  op;
  logic [2:0]  rs1, rs2, rd, dbg_addr;
  logic [5:0]  imm;
  logic [1:0]  cz;
  logic        busy, done, skipped, illegal, carry_flag, zero_flag;
  logic [15:0] result, dbg_data;

  int          tests = 0;
  int          fails = 0;
  int          o_lat;
  logic [15:0] o_res;
  logic        o_skip, o_ill;

  mc_exec_unit #(.WIDTH(16), .NREGS(8), .IMM_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .imm        (imm),
    .use_imm    (use_imm),
    .cz         (cz),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .skipped    (skipped),
    .illegal    (illegal),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [31:0] val);
    dbg_addr = idx;
    #1;
    check(tag, 32'(dbg_data), val);
  endtask

  // Issue one op, keep start high for 'hold' extra edges, scramble the
  // inputs after acceptance, wait for done, then step into IDLE.
  task automatic run_op(input logic [3:0] o, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] d, input logic [5:0] im, input logic ui,
                        input logic [1:0] c, input int hold);
    @(negedge clk);
    op = o; rs1 = s1; rs2 = s2; rd = d; imm = im; use_imm = ui; cz = c; start = 1'b1;
    o_lat = 0;
    do begin
      @(posedge clk);
      o_lat++;
      @(negedge clk);
      if (o_lat == 1) begin
        op = 4'hE; rs1 = 3'd7; rs2 = 3'd7; rd = 3'd7; imm = 6'h15; use_imm = ~ui; cz = 2'b01;
      end
      if (o_lat > hold) start = 1'b0;
    end while (!done && o_lat < 60);
    o_res  = result;
    o_skip = skipped;
    o_ill  = illegal;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_op(input string tag, input int lat, input logic [31:0] res,
                           input logic skp, input logic ill, input logic c, input logic z);
    check({tag, " lat"},   32'(o_lat), 32'(lat));
    check({tag, " res"},   32'(o_res), res);
    check({tag, " skip"},  32'(o_skip), 32'(skp));
    check({tag, " ill"},   32'(o_ill), 32'(ill));
    check({tag, " carry"}, 32'(carry_flag), 32'(c));
    check({tag, " zero"},  32'(zero_flag), 32'(z));
  endtask

  initial begin
    int dt[3];
    int nd, cyc, busy_cnt;
    logic [15:0] acc;

    reset = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    imm = '0; use_imm = 1'b0; cz = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    check("rst busy",   32'(busy), 32'd0);
    check("rst done",   32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst flags",  32'({carry_flag, zero_flag}), 32'd0);
    reset = 1'b1;

    run_op(OP_ADD, 3'd0, 3'd0, 3'd1, 6'h3F, 1'b1, 2'b00, 0);
    expect_op("ld r1", 3, 32'hFFFF, 0, 0, 0, 0);
    run_op(OP_ADD, 3'd0, 3'd0, 3'd2, 6'h01, 1'b1, 2'b00, 0);
    expect_op("ld r2", 3, 32'h0001, 0, 0, 0, 0);
    run_op(OP_ADD, 3'd1, 3'd2, 3'd3, 6'h00, 1'b0, 2'b00, 0);
    expect_op("add wrap", 3, 32'h0000, 0, 0, 1, 1);
    chk_reg("add wrap r3", 3'd3, 32'h0);

    run_op(OP_ADD, 3'd0, 3'd0, 3'd6, 6'h05, 1'b1, 2'b00, 0);
    expect_op("ld r6", 3, 32'h0005, 0, 0, 0, 0);
    run_op(OP_ADD, 3'd1, 3'd2, 3'd6, 6'h00, 1'b0, 2'b10, 0);
    expect_op("skip c", 3, 32'h0000, 1, 0, 0, 0);
    chk_reg("skip c r6", 3'd6, 32'h5);
    run_op(OP_ADD, 3'd1, 3'd2, 3'd7, 6'h00, 1'b0, 2'b00, 0);
    expect_op("set c", 3, 32'h0000, 0, 0, 1, 1);
    run_op(OP_ADD, 3'd6, 3'd2, 3'd4, 6'h00, 1'b0, 2'b10, 0);
    expect_op("take c", 3, 32'h0006, 0, 0, 0, 0);
    chk_reg("take c r4", 3'd4, 32'h6);
    run_op(OP_ADD, 3'd6, 3'd0, 3'd4, 6'h03, 1'b1, 2'b01, 0);
    expect_op("skip z", 3, 32'h0008, 1, 0, 0, 0);
    chk_reg("skip z r4", 3'd4, 32'h6);

    run_op(OP_ADD, 3'd1, 3'd2, 3'd0, 6'h00, 1'b0, 2'b00, 0);
    expect_op("rd0", 3, 32'h0000, 0, 0, 1, 1);
    chk_reg("rd0 dbg", 3'd0, 32'h0);
    run_op(OP_ADD, 3'd6, 3'd2, 3'd5, 6'h00, 1'b0, 2'b11, 0);
    expect_op("addc", 3, 32'h0007, 0, 0, 0, 0);
    chk_reg("addc r5", 3'd5, 32'h7);
    run_op(OP_ADD, 3'd0, 3'd0, 3'd5, 6'h3E, 1'b1, 2'b00, 0);
    expect_op("imm neg", 3, 32'hFFFE, 0, 0, 0, 0);
    chk_reg("imm r5", 3'd5, 32'hFFFE);

    run_op(OP_SUB, 3'd6, 3'd2, 3'd3, 6'h00, 1'b0, 2'b00, 0);
    expect_op("sub", 3, 32'h0004, 0, 0, 0, 0);
    run_op(OP_SUB, 3'd2, 3'd6, 3'd3, 6'h00, 1'b0, 2'b00, 0);
    expect_op("sub borrow", 3, 32'hFFFC, 0, 0, 1, 0);
    run_op(OP_NAND, 3'd1, 3'd1, 3'd4, 6'h00, 1'b0, 2'b00, 0);
    expect_op("nand", 3, 32'h0000, 0, 0, 1, 1);
    run_op(OP_SLT, 3'd1, 3'd2, 3'd4, 6'h00, 1'b0, 2'b00, 0);
    expect_op("slt", 3, 32'h0001, 0, 0, 1, 0);
    run_op(OP_SRL, 3'd6, 3'd0, 3'd3, 6'h02, 1'b1, 2'b00, 0);
    expect_op("srl", 3, 32'h0001, 0, 0, 0, 0);
    run_op(OP_SLL, 3'd1, 3'd0, 3'd3, 6'h04, 1'b1, 2'b00, 0);
    expect_op("sll", 3, 32'hFFF0, 0, 0, 1, 0);
    run_op(OP_SLL, 3'd6, 3'd0, 3'd3, 6'h00, 1'b1, 2'b00, 0);
    expect_op("sll0", 3, 32'h0005, 0, 0, 0, 0);
    run_op(OP_XOR, 3'd1, 3'd6, 3'd3, 6'h00, 1'b0, 2'b00, 0);
    expect_op("xor", 3, 32'hFFFA, 0, 0, 0, 0);
    run_op(OP_OR, 3'd2, 3'd6, 3'd3, 6'h00, 1'b0, 2'b00, 0);
    expect_op("or", 3, 32'h0005, 0, 0, 0, 0);

    run_op(OP_SLL, 3'd2, 3'd0, 3'd1, 6'h08, 1'b1, 2'b00, 0);
    expect_op("ld 0100", 3, 32'h0100, 0, 0, 0, 0);
    run_op(OP_MUL, 3'd1, 3'd1, 3'd3, 6'h00, 1'b0, 2'b00, 2);
    expect_op("mul ovf", 18, 32'h0000, 0, 0, 1, 1);
    busy_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("mul no requeue", 32'(busy_cnt), 32'd0);
    run_op(OP_ADD, 3'd0, 3'd0, 3'd1, 6'h07, 1'b1, 2'b00, 0);
    run_op(OP_ADD, 3'd0, 3'd0, 3'd2, 6'h09, 1'b1, 2'b00, 0);
    run_op(OP_MUL, 3'd1, 3'd2, 3'd3, 6'h00, 1'b0, 2'b00, 0);
    expect_op("mul 7x9", 18, 32'h003F, 0, 0, 0, 0);
    chk_reg("mul r3", 3'd3, 32'h3F);

    run_op(4'hF, 3'd1, 3'd2, 3'd3, 6'h00, 1'b0, 2'b00, 0);
    expect_op("illegal", 3, 32'h0000, 0, 1, 0, 0);
    chk_reg("illegal r3", 3'd3, 32'h3F);

    @(negedge clk);
    op = OP_ADD; rs1 = 3'd0; imm = 6'h01; use_imm = 1'b1; rd = 3'd2; cz = 2'b00; start = 1'b1;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        dt[nd] = cyc;
        nd++;
      end
    end
    start = 1'b0;
    check("b2b count", 32'(nd), 32'd3);
    if (nd == 3) begin
      check("b2b first", 32'(dt[0]), 32'd3);
      check("b2b gap1", 32'(dt[1] - dt[0]), 32'd4);
      check("b2b gap2", 32'(dt[2] - dt[1]), 32'd4);
    end
    @(posedge clk);
    @(negedge clk);

    op = OP_MUL; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd3; use_imm = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid mul busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort no done", 32'(nd), 32'd0);
    acc = '0;
    for (int i = 1; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      acc = acc | dbg_data;
    end
    check("abort regs", 32'(acc), 32'd0);
    check("abort flags", 32'({carry_flag, zero_flag}), 32'd0);
    check("abort result", 32'(result), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_exec_unit.md
Name: mc_exec_unit

Overview:
- Parametrised successor to the single-width multicycle datapath execute path: register file, A/B operand latches, ALU with carry/zero flag registers, condition-gated writeback and an iterative shift-add multiplier.
- Sequenced by an internal FSM with a start/busy/done handshake, so the core controller issues one operation and waits for done.
- Sits between instruction decode (which supplies op, register indices, immediate and the cz condition field) and the memory/PC logic, which consumes result.

Parameters:
- WIDTH, 16: datapath and register width in bits (>=8).
- NREGS, 8: number of architectural registers, power of two; R0 is hardwired to zero.
- IMM_W, 6: immediate field width, sign-extended to WIDTH.
- RA_W, $clog2(NREGS): register index width (derived).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  issue request; sampled only in IDLE
- op  in  4  ALU operation code (package encoding)
- rs1  in  RA_W  source register A index
- rs2  in  RA_W  source register B index
- rd  in  RA_W  destination register index
- imm  in  IMM_W  immediate value
- use_imm  in  1  1 = sign-extended imm replaces B
- cz  in  2  write condition: 00 always, 10 if carry flag, 01 if zero flag, 11 always with carry-in to ADD
- busy  out  1  high in READ, EXEC and WB
- done  out  1  one-cycle pulse in the WB cycle
- result  out  WIDTH  ALU result, valid while done
- skipped  out  1  valid with done; 1 = condition false, no writeback
- illegal  out  1  valid with done; 1 = unknown op
- carry_flag  out  1  architectural carry flag
- zero_flag  out  1  architectural zero flag
- dbg_addr  in  RA_W  debug read index
- dbg_data  out  WIDTH  combinational register read (0 for R0)

Behaviour:
- Reset (asynchronous, reset=0): FSM goes to IDLE; all registers, flags, operand latches and multiplier state cleared to 0; all outputs 0. A reset mid-operation aborts it with no register write.
- FSM states: IDLE -> (start) READ -> EXEC -> WB -> IDLE.
  - IDLE: on start, capture op/rs1/rs2/rd/imm/use_imm/cz into issue registers. Later input changes are ignored.
  - READ: latch A=reg[rs1] and B=use_imm ? sext(imm) : reg[rs2]. R0 reads as 0.
  - EXEC: one cycle for all ops except MUL. MUL runs exactly WIDTH cycles of shift-add via a counter counting down from WIDTH-1. The result register is captured on the last EXEC cycle.
  - WB: done=1. Flags and reg[rd] are evaluated together with the condition. busy drops next cycle.
- Latency: start high at edge N gives done high in cycle N+3 (non-MUL), N+2+WIDTH (MUL). Back-to-back: start may be held high; the next op is accepted in the IDLE cycle after WB.
- start while busy: ignored, no queueing.
- Arithmetic, all mod 2^WIDTH:
  - ADD: carry = carry-out; with cz=11, carry-in = carry_flag.
  - SUB: A-B; carry = borrow (A<B unsigned).
  - AND, OR, NAND, XOR: carry preserved.
  - SLT: signed compare, result 1/0; carry preserved.
  - SLL, SRL: shift by B[$clog2(WIDTH)-1:0]; carry = last bit shifted out, 0 if shift amount is 0.
  - MUL: unsigned, low WIDTH bits; carry=1 if the high half is nonzero.
  - zero = (result==0) for all ops.
- Condition is evaluated against flags as they stood at issue.
  - If false: skipped=1, no register write, flags unchanged.
  - If true: write reg[rd] unless rd==0; flags update.
- Illegal op: result=0, illegal=1, no write, flags unchanged, latency as non-MUL.
- Register write and dbg_data: a write lands at the WB clock edge, and dbg_data reflects it the following cycle.

Decomposition:
- Package mc_pkg:
  - ALU op encodings: ADD 0, SUB 1, AND 2, OR 3, NAND 4, XOR 5, SLT 6, SLL 7, SRL 8, MUL 9; 10-15 illegal.
  - cz encodings.
  - FSM state enum.
- One sub-module: mc_regfile (NREGS x WIDTH, 2 read ports, 1 write port, debug read port, R0 hardwired zero, asynchronous clear).
- ALU and multiplier stay inline in mc_exec_unit.

Test Plan:
- Reset then ADD (WIDTH=16): preload R1=0xFFFF, R2=0x0001 via prior ADD-immediates; ADD rd=3, cz=00 -> done at N+3, result=0x0000, R3=0, carry=1, zero=1.
- Conditional skip: carry=0, ADD cz=10 rd=4 -> done with skipped=1, R4 and flags unchanged. Repeat after a carry-setting op -> write occurs.
- MUL: R1=0x0100, R2=0x0100 -> done exactly 18 cycles after start, result=0x0000, carry=1, zero=1. R1=7, R2=9 -> 0x003F, carry=0.
- Immediate and R0: ADD rs1=0, imm=6'h3E, use_imm=1, rd=5 -> R5=0xFFFE. Then ADD rd=0 -> dbg_data(0)=0.
- Handshake: start pulsed in READ/EXEC of a MUL -> ignored, exactly one done. start held high -> ops issue every 4 cycles.
- Reset mid-MUL (reset=0 for 1 cycle during EXEC) -> busy=0 immediately, no done, all registers 0. Illegal op 0xF -> illegal=1, no write.
